llrf_lb_arb: RTL

- Write arbiter and scheduler in front of the llrf DSP local-bus decoder (lb_data/lb_addr/lb_write, clk domain).
- Shares the single write port between two requesters: host register writes, which cannot be backpressured, and an on-chip setpoint sequencer, which uses a req/ack handshake.
- Host writes are buffered in a small FIFO. All writes are deferred while the DSP asserts hold, so register updates never land mid-pulse or mid-waveform.

---
 rtl/llrf_lb_arb.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/llrf_lb_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | llrf_lb_arb: host-FIFO / sequencer write arbiter for the llrf local bus.  |
// | Optional: LB_ARB_FAIR_EN enables host/sequencer round-robin.  Rev 1.0     |
// +----------------------------------------------------------------------------+
module llrf_lb_arb #(
  parameter int FIFO_AW = 2,
  parameter int AW      = 16,
  parameter int DW      = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DW-1:0]      host_data,
  input  logic [AW-1:0]      host_addr,
  input  logic               host_write,
  input  logic [DW-1:0]      seq_data,
  input  logic [AW-1:0]      seq_addr,
  input  logic               seq_req,
  output logic               seq_ack,
  input  logic               hold,
  output logic [DW-1:0]      lb_data,
  output logic [AW-1:0]      lb_addr,
  output logic               lb_write,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               overflow,
  input  logic               overflow_clr
);

  localparam int                 c_DEPTH      = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   c_FULL_COUNT = (FIFO_AW+1)'(c_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOST = 2'd1,
    SEQ  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [AW+DW-1:0]      r_mem [c_DEPTH];
  logic [FIFO_AW-1:0]    r_wptr;
  logic [FIFO_AW-1:0]    r_rptr;
  logic [FIFO_AW:0]      r_count;
  logic                  r_overflow;
  logic                  r_lb_write;
  logic [AW-1:0]         r_lb_addr;
  logic [DW-1:0]         r_lb_data;
  logic                  r_seq_ack;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_host_win;
  logic                  w_grant_host;
  logic                  w_grant_seq;
  logic                  w_push_ok;
  logic                  w_drop;
  logic [AW+DW-1:0]      w_head;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_FULL_COUNT);
  assign w_head  = r_mem[r_rptr];

`ifdef LB_ARB_FAIR_EN
  // Remembers the last granted source; reset value makes the host win first.
  logic r_last_host;

  assign w_host_win = !w_empty && (!seq_req || !r_last_host);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_host <= 1'b0;
    end else if (w_grant_host || w_grant_seq) begin
      r_last_host <= w_grant_host;
    end
  end
`else
  assign w_host_win = !w_empty;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_grant_host = 1'b0;
    w_grant_seq  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!hold) begin
          if (w_host_win) begin
            w_grant_host = 1'b1;
            w_state_nxt  = HOST;
          end else if (seq_req) begin
            w_grant_seq  = 1'b1;
            w_state_nxt  = SEQ;
          end
        end
      end
      HOST:    w_state_nxt = IDLE;
      SEQ:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // A push into a full FIFO survives only when the head leaves in the same cycle.
  assign w_push_ok = host_write && (!w_full || w_grant_host);
  assign w_drop    = host_write && w_full && !w_grant_host;

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wptr] <= {host_addr, host_data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_push_ok) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_grant_host) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push_ok, w_grant_host})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (overflow_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  // Bus registers load only on a grant so address/data never move without a strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lb_write <= 1'b0;
      r_lb_addr  <= '0;
      r_lb_data  <= '0;
      r_seq_ack  <= 1'b0;
    end else begin
      r_lb_write <= w_grant_host || w_grant_seq;
      r_seq_ack  <= w_grant_seq;
      if (w_grant_host) begin
        {r_lb_addr, r_lb_data} <= w_head;
      end else if (w_grant_seq) begin
        r_lb_addr <= seq_addr;
        r_lb_data <= seq_data;
      end
    end
  end

  assign lb_write   = r_lb_write;
  assign lb_addr    = r_lb_addr;
  assign lb_data    = r_lb_data;
  assign seq_ack    = r_seq_ack;
  assign fifo_level = r_count;
  assign overflow   = r_overflow;

endmodule
`default_nettype wire
